// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
//
// Writeback/commit stage. Each cycle one execution unit that presents a valid
// result is picked round-robin. Its result becomes a single register-file write,
// or an exception report if the unit flagged an error. The unit then gets a
// one-cycle clear pulse. A flush discards every pending result: the FSM moves to
// DRAIN and pulses clear once to every valid unit until all valids have fallen.
//
// Optional feature macro: COMMIT_STATS_EN
//   Adds the commit_count and error_count 32-bit statistics outputs.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   unit_res      per-unit result, unit i at [i*XLEN +: XLEN]
//   unit_rd       per-unit destination register, unit i at [i*REG_ADDR_W +: REG_ADDR_W]
//   unit_valid    per-unit result-valid, held until cleared
//   unit_error    per-unit error flag accompanying the result
//   unit_clear    one-cycle acknowledge back to each unit
//   flush         discard every pending result
//   wr_en         register-file write strobe
//   wr_addr       register-file write address
//   wr_data       register-file write data
//   exc_valid     one-cycle error report
//   exc_unit      index of the erroring unit
//   exc_rd        destination of the erroring result
//   commit_count  (COMMIT_STATS_EN) number of wr_en cycles, wraps at 2^32
//   error_count   (COMMIT_STATS_EN) number of exc_valid cycles, wraps at 2^32
//   draining      high while in the DRAIN state
// -----------------------------------------------------------------------------

package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
endpackage

module commit_unit #(
  parameter int NUM_UNITS  = 4,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS*XLEN-1:0]       unit_res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS-1:0]            unit_error,
  output logic [NUM_UNITS-1:0]            unit_clear,
  input  logic                            flush,
  output logic                            wr_en,
  output logic [REG_ADDR_W-1:0]           wr_addr,
  output logic [XLEN-1:0]                 wr_data,
  output logic                            exc_valid,
  output logic [2:0]                      exc_unit,
  output logic [REG_ADDR_W-1:0]           exc_rd,
`ifdef COMMIT_STATS_EN
  output logic [31:0]                     commit_count,
  output logic [31:0]                     error_count,
`endif
  output logic                            draining
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_UNITS - 1);
  localparam logic [3:0] NUM_U4   = 4'(NUM_UNITS);

  state_e                r_state;
  logic [2:0]            r_rr_ptr;
  logic [NUM_UNITS-1:0]  r_unit_clear;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;
  logic                  r_exc_valid;
  logic [2:0]            r_exc_unit;
  logic [REG_ADDR_W-1:0] r_exc_rd;
  logic                  r_draining;

  // Per-unit views padded to 8 entries so a 3-bit grant index always fits.
  logic [7:0]            w_elig;
  logic [7:0]            w_err;
  logic [REG_ADDR_W-1:0] w_rd_arr  [8];
  logic [XLEN-1:0]       w_res_arr [8];

  logic                  w_found;
  logic [2:0]            w_grant;
  logic [NUM_UNITS-1:0]  w_grant_onehot;

  // A unit whose clear is high this cycle still shows valid (it drops valid one
  // cycle later), so it is masked out to avoid committing the same result twice.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_elig = '0;
    w_err  = '0;
    for (int i = 0; i < 8; i++) begin
      w_rd_arr[i]  = '0;
      w_res_arr[i] = '0;
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_elig[i]    = unit_valid[i] & ~r_unit_clear[i];
      w_err[i]     = unit_error[i];
      w_rd_arr[i]  = unit_rd[i*REG_ADDR_W +: REG_ADDR_W];
      w_res_arr[i] = unit_res[i*XLEN +: XLEN];
    end
  end

  // Round-robin search: first eligible index at or after r_rr_ptr, wrapping.
  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = {1'b0, r_rr_ptr} + 4'(k);
      if (idx >= NUM_U4) begin
        idx = idx - NUM_U4;
      end
      if (!w_found && w_elig[idx[2:0]]) begin
        w_found = 1'b1;
        w_grant = idx[2:0];
      end
    end
  end

  always_comb begin
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_found && (3'(i) == w_grant)) begin
        w_grant_onehot[i] = 1'b1;
      end
    end
  end

  // FSM with registered outputs. Pulse-type outputs default to 0 each cycle and
  // are overridden below only where a commit, exception or drain clear occurs.
  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_rr_ptr     <= '0;
      r_unit_clear <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_exc_valid  <= 1'b0;
      r_exc_unit   <= '0;
      r_exc_rd     <= '0;
      r_draining   <= 1'b0;
    end else begin
      r_unit_clear <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_exc_valid  <= 1'b0;
      r_exc_unit   <= '0;
      r_exc_rd     <= '0;

      case (r_state)
        RUN: begin
          if (flush) begin
            // Flush wins over any valid result: nothing is granted this cycle.
            r_state    <= DRAIN;
            r_draining <= 1'b1;
          end else if (w_found) begin
            r_unit_clear <= w_grant_onehot;
            r_rr_ptr     <= (w_grant == LAST_IDX) ? 3'd0 : w_grant + 3'd1;
            if (w_err[w_grant]) begin
              r_exc_valid <= 1'b1;
              r_exc_unit  <= w_grant;
              r_exc_rd    <= w_rd_arr[w_grant];
            end else if (w_rd_arr[w_grant] != '0) begin
              // Writes to x0 are dropped; the result is still acknowledged.
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_rd_arr[w_grant];
              r_wr_data <= w_res_arr[w_grant];
            end
          end
        end

        DRAIN: begin
          // Pulse every valid unit once; a unit cleared last cycle still shows
          // valid for one more cycle and must not be pulsed again.
          r_unit_clear <= unit_valid & ~r_unit_clear;
          if ((unit_valid == '0) && !flush) begin
            r_state    <= RUN;
            r_draining <= 1'b0;
            r_rr_ptr   <= '0;
          end
        end

        default: begin
          r_state    <= RUN;
          r_draining <= 1'b0;
        end
      endcase
    end
  end

  assign unit_clear = r_unit_clear;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign exc_valid  = r_exc_valid;
  assign exc_unit   = r_exc_unit;
  assign exc_rd     = r_exc_rd;
  assign draining   = r_draining;

`ifdef COMMIT_STATS_EN
  logic [31:0] r_commit_count;
  logic [31:0] r_error_count;

  // Counts cycles in which the registered strobes are high; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_count <= '0;
      r_error_count  <= '0;
    end else begin
      if (r_wr_en) begin
        r_commit_count <= r_commit_count + 32'd1;
      end
      if (r_exc_valid) begin
        r_error_count <= r_error_count + 32'd1;
      end
    end
  end

  assign commit_count = r_commit_count;
  assign error_count  = r_error_count;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_commit_unit
//
// Directed bench for commit_unit with NUM_UNITS=4. Inputs change 1 time unit
// after each rising edge; outputs are checked at the same point, i.e. after the
// registered outputs have settled. Unit handshakes (drop valid one cycle after
// clear, re-assert later) are mimicked by hand in the step sequence.
// -----------------------------------------------------------------------------

module tb_commit_unit;

  localparam int NU = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic              clk;
  logic              rst;
  logic [NU*XL-1:0]  unit_res;
  logic [NU*RW-1:0]  unit_rd;
  logic [NU-1:0]     unit_valid;
  logic [NU-1:0]     unit_error;
  logic [NU-1:0]     unit_clear;
  logic              flush;
  logic              wr_en;
  logic [RW-1:0]     wr_addr;
  logic [XL-1:0]     wr_data;
  logic              exc_valid;
  logic [2:0]        exc_unit;
  logic [RW-1:0]     exc_rd;
  logic              draining;

  int total;
  int bad;

  commit_unit #(
    .NUM_UNITS  (NU),
    .XLEN       (XL),
    .REG_ADDR_W (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .unit_res   (unit_res),
    .unit_rd    (unit_rd),
    .unit_valid (unit_valid),
    .unit_error (unit_error),
    .unit_clear (unit_clear),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .exc_valid  (exc_valid),
    .exc_unit   (exc_unit),
    .exc_rd     (exc_rd),
    .draining   (draining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_outs(input string tag,
                             input logic          e_wr_en,
                             input logic [RW-1:0] e_wr_addr,
                             input logic [XL-1:0] e_wr_data,
                             input logic          e_exc_valid,
                             input logic [2:0]    e_exc_unit,
                             input logic [RW-1:0] e_exc_rd,
                             input logic [NU-1:0] e_clear,
                             input logic          e_draining);
    check({tag, ".wr_en"},     64'(wr_en),      64'(e_wr_en));
    check({tag, ".wr_addr"},   64'(wr_addr),    64'(e_wr_addr));
    check({tag, ".wr_data"},   64'(wr_data),    64'(e_wr_data));
    check({tag, ".exc_valid"}, 64'(exc_valid),  64'(e_exc_valid));
    check({tag, ".exc_unit"},  64'(exc_unit),   64'(e_exc_unit));
    check({tag, ".exc_rd"},    64'(exc_rd),     64'(e_exc_rd));
    check({tag, ".clear"},     64'(unit_clear), 64'(e_clear));
    check({tag, ".draining"},  64'(draining),   64'(e_draining));
  endtask

  task automatic set_unit(input int i, input logic v, input logic e,
                          input logic [RW-1:0] rd, input logic [XL-1:0] res);
    unit_valid[i]        = v;
    unit_error[i]        = e;
    unit_rd[i*RW +: RW]  = rd;
    unit_res[i*XL +: XL] = res;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    unit_res   = '0;
    unit_rd    = '0;
    unit_valid = '0;
    unit_error = '0;

    // Reset state
    tick();
    tick();
    expect_outs("reset", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;

    // Single result: unit 0, rd=3, res=0xAA
    set_unit(0, 1, 0, 5'd3, 32'h0000_00AA);
    tick();
    expect_outs("single", 1, 5'd3, 32'hAA, 0, 0, 0, 4'b0001, 0);
    tick();  // unit still valid while its clear is high: must be masked
    expect_outs("single_mask", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    set_unit(0, 0, 0, 0, 0);
    tick();
    expect_outs("single_idle", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Return rr_ptr to 0 before the round-robin sequence
    rst = 1'b1;
    tick();
    expect_outs("rst2", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;

    // Round-robin: all four valid, each unit drops valid the cycle after its
    // clear and re-asserts one cycle later
    for (int i = 0; i < NU; i++) begin
      set_unit(i, 1, 0, RW'(i + 1), 32'h100 + 32'(i));
    end
    tick();
    expect_outs("rr0", 1, 5'd1, 32'h100, 0, 0, 0, 4'b0001, 0);
    set_unit(0, 0, 0, 0, 0);
    tick();
    expect_outs("rr1", 1, 5'd2, 32'h101, 0, 0, 0, 4'b0010, 0);
    set_unit(1, 0, 0, 0, 0);
    set_unit(0, 1, 0, 5'd1, 32'h200);
    tick();
    expect_outs("rr2", 1, 5'd3, 32'h102, 0, 0, 0, 4'b0100, 0);
    set_unit(2, 0, 0, 0, 0);
    set_unit(1, 1, 0, 5'd2, 32'h201);
    tick();
    expect_outs("rr3", 1, 5'd4, 32'h103, 0, 0, 0, 4'b1000, 0);
    tick();
    expect_outs("rr4", 1, 5'd1, 32'h200, 0, 0, 0, 4'b0001, 0);
    for (int i = 0; i < NU; i++) begin
      set_unit(i, 0, 0, 0, 0);
    end
    tick();
    expect_outs("rr_idle", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Error: unit 2, rd=7 (rr_ptr is 1 here)
    set_unit(2, 1, 1, 5'd7, 32'hDEAD_BEEF);
    tick();
    expect_outs("err", 0, 0, 0, 1, 3'd2, 5'd7, 4'b0100, 0);
    tick();
    expect_outs("err_mask", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    set_unit(2, 0, 0, 0, 0);

    // x0 discard: unit 1, rd=0 (rr_ptr is 3 here)
    set_unit(1, 1, 0, 5'd0, 32'hFFFF_FFFF);
    tick();
    expect_outs("x0", 0, 0, 0, 0, 0, 0, 4'b0010, 0);
    tick();
    expect_outs("x0_mask", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    set_unit(1, 0, 0, 0, 0);

    // Flush with units 0 and 3 valid in the same cycle: flush wins (rr_ptr is 2)
    set_unit(0, 1, 0, 5'd6, 32'h66);
    set_unit(3, 1, 0, 5'd8, 32'h88);
    flush = 1'b1;
    tick();
    expect_outs("flush", 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    flush = 1'b0;
    tick();
    expect_outs("drain_clr", 0, 0, 0, 0, 0, 0, 4'b1001, 1);
    tick();
    expect_outs("drain_mask", 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    set_unit(0, 0, 0, 0, 0);
    set_unit(3, 0, 0, 0, 0);
    tick();
    expect_outs("drain_exit", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // rr_ptr must be 0 after DRAIN: units 1 and 3 valid -> unit 1 first
    set_unit(1, 1, 0, 5'd9,  32'h11);
    set_unit(3, 1, 0, 5'd10, 32'h33);
    tick();
    expect_outs("ptr0", 1, 5'd9, 32'h11, 0, 0, 0, 4'b0010, 0);
    set_unit(1, 0, 0, 0, 0);
    tick();
    expect_outs("ptr0_next", 1, 5'd10, 32'h33, 0, 0, 0, 4'b1000, 0);
    set_unit(3, 0, 0, 0, 0);
    tick();
    expect_outs("ptr0_idle", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Reset mid-stream while unit 1 is granted; unit 1 keeps valid throughout
    set_unit(1, 1, 0, 5'd5, 32'h55);
    tick();
    expect_outs("mid_grant", 1, 5'd5, 32'h55, 0, 0, 0, 4'b0010, 0);
    rst = 1'b1;
    tick();
    expect_outs("mid_reset", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    rst = 1'b0;
    tick();
    expect_outs("mid_regrant", 1, 5'd5, 32'h55, 0, 0, 0, 4'b0010, 0);
    tick();
    expect_outs("mid_once", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    set_unit(1, 0, 0, 0, 0);
    tick();
    expect_outs("mid_idle", 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

Writeback/commit stage on the consumer side of the execution units' commiter interface. Each cycle it selects one execution unit presenting a valid result via round-robin and registers a single register-file write. It returns a one-cycle `clear` pulse to that unit and reports units that flagged an error. It sits between the ALU bank and the register-file write port and is the sole driver of every unit's `clear`.

## Interface
Parameters:
- NUM_UNITS, 4, number of execution units served (2..8)
- XLEN, core_config_pkg::XLEN (32), result width
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register address width

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset, synchronous and active-high
- unit_res  in  NUM_UNITS*XLEN  result of unit i at bits [i*XLEN +: XLEN]
- unit_rd  in  NUM_UNITS*REG_ADDR_W  destination of unit i
- unit_valid  in  NUM_UNITS  unit i presents a result, held until cleared
- unit_error  in  NUM_UNITS  unit i result is erroneous (overflow / illegal op)
- unit_clear  out  NUM_UNITS  one-cycle acknowledge to unit i
- flush  in  1  discard every pending result
- wr_en  out  1  register-file write strobe
- wr_addr  out  REG_ADDR_W  write address
- wr_data  out  XLEN  write data
- exc_valid  out  1  one-cycle error report
- exc_unit  out  3  index of the erroring unit
- exc_rd  out  REG_ADDR_W  destination of the erroring result
- draining  out  1  high while in DRAIN state

## Operation
- FSM states: RUN, DRAIN. Reset to RUN; rr_ptr = 0.
- RUN, no flush: eligible[i] = unit_valid[i] & ~unit_clear[i]. The previously granted unit is masked while its clear is high.
- Grant goes to the first eligible index at or after rr_ptr, wrapping modulo NUM_UNITS. On a grant, rr_ptr <= grant+1 with wrap.
- Granted, unit_error=0, rd!=0: wr_en=1, wr_addr=rd, wr_data=res.
- Granted, unit_error=0, rd==0: wr_en=0. The result is discarded but still cleared.
- Granted, unit_error=1: wr_en=0; exc_valid=1, exc_unit=grant, exc_rd=rd. The result is still cleared.
- unit_clear[grant]=1 for exactly one cycle. All other clear bits are 0.
- No eligible unit: all outputs are 0 next cycle and rr_ptr is unchanged.
- flush in RUN: no grant in that cycle. The next state is DRAIN and all wr_en/exc_valid are 0.
- DRAIN: each cycle unit_clear = unit_valid & ~unit_clear, so each valid unit is pulsed once and not re-pulsed in the following cycle. wr_en=0 and exc_valid=0.
- DRAIN exits to RUN when unit_valid==0 and flush==0. flush held high keeps the FSM in DRAIN. rr_ptr resets to 0 on the DRAIN→RUN transition.
- Reset mid-operation: all outputs are 0 next cycle, state is RUN, and rr_ptr=0. Units keep valid and are re-granted normally.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: unit_valid sampled in cycle N produces wr_en/exc_valid and unit_clear in cycle N+1.
- A unit samples clear at the end of N+1 and drops valid in N+2. The masking rule prevents a double commit in N+1.
- Throughput: one commit per cycle aggregate. A single unit commits at most once every 2 cycles.
- wr_en and exc_valid are never high in the same cycle.
- At most one bit of unit_clear is set in RUN. Multiple bits may be set in DRAIN.
- Simultaneous flush and valid in RUN: flush wins and nothing is written.

## Configuration
- COMMIT_STATS_EN defined adds two 32-bit outputs:
  - commit_count: increments on every wr_en cycle.
  - error_count: increments on every exc_valid cycle.
  - Both counters reset to 0 and wrap at 2^32.
- COMMIT_STATS_EN undefined: the counter ports and logic are absent.

## Test plan
- Single result: unit 0 valid, rd=3, res=0x0000_00AA. Expect wr_en=1, wr_addr=3, wr_data=0xAA one cycle later, unit_clear=4'b0001 for one cycle, no second write.
- Round-robin, NUM_UNITS=4: units 0..3 valid together, rd=1..4, each re-asserting valid 1 cycle after its clear. Expect grant order 0,1,2,3,0 with one write per cycle.
- Error: unit 2 valid, unit_error=1, rd=7. Expect exc_valid=1, exc_unit=2, exc_rd=7, wr_en=0, unit_clear=4'b0100.
- x0 discard: unit 1 valid, rd=0, res=0xFFFF_FFFF. Expect wr_en=0, exc_valid=0, unit_clear=4'b0010.
- Flush: units 0 and 3 valid, flush pulsed one cycle. Expect no write, draining=1, unit_clear=4'b1001 once, then RUN with rr_ptr=0 once valids fall.
- Reset mid-stream: assert rst while unit 1 granted. Expect all outputs 0 next cycle, then unit 1 re-committed once after release.
